// File: rtl/i2s_tx_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_stream_if
// Purpose  : Valid/ready stereo sample stream into the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_tx_stream_if #(
   parameter int DATA_BITS = 16
) ();
   logic                 s_valid;
   logic                 s_ready;
   logic [DATA_BITS-1:0] s_left;
   logic [DATA_BITS-1:0] s_right;

   modport master (output s_valid, s_left, s_right, input s_ready);
   modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface
`default_nettype wire

// File: rtl/i2s_tx_stream.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_stream
// Purpose  : Stereo I2S transmitter, BCK from a fractional accumulator, samples
//            via valid/ready into a one-frame holding register.
//            Define I2S_TX_LEFT_JUST_EN for left-justified output.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_stream #(
   parameter int CLK_HZ    = 6000000,
   parameter int BCK_HZ    = 1411200,
   parameter int DATA_BITS = 16,
   parameter int SLOT_BITS = 16,
   parameter int ACC_BITS  = 25
) (
   input  wire logic      clk,
   input  wire logic      sys_rst_i,
   i2s_tx_stream_if.slave s_if,
   output logic           i2s_bck,
   output logic           i2s_lrck,
   output logic           i2s_din,
   output logic           frame_start,
   output logic           underrun
);
   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int IDX_W      = $clog2(FRAME_BITS);
   localparam logic [IDX_W-1:0]    C_LAST_IDX = IDX_W'(FRAME_BITS - 1);
   localparam logic [IDX_W-1:0]    C_SLOT     = IDX_W'(SLOT_BITS);
   localparam logic [IDX_W-1:0]    C_ONE      = IDX_W'(1);
   localparam logic [ACC_BITS-1:0] C_INC      = ACC_BITS'(2 * BCK_HZ);
   localparam logic [ACC_BITS-1:0] C_MOD      = ACC_BITS'(CLK_HZ);

   if (SLOT_BITS < DATA_BITS) begin : g_err_slot
      $error("i2s_tx_stream: SLOT_BITS must be >= DATA_BITS");
   end
   if (2 * BCK_HZ >= CLK_HZ) begin : g_err_bck
      $error("i2s_tx_stream: 2*BCK_HZ must be < CLK_HZ");
   end
   if ((longint'(CLK_HZ) + 2 * longint'(BCK_HZ)) >= (longint'(1) << ACC_BITS)) begin : g_err_acc
      $error("i2s_tx_stream: ACC_BITS cannot hold CLK_HZ+2*BCK_HZ");
   end

   logic [ACC_BITS-1:0]  acc_q, acc_d, sum;
   logic                 tick, fall, boundary, accept, slot_hi, lj_bit;
   logic                 bck_q, bck_d, lrck_q, lrck_d, din_q, din_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d, p, k;
   logic                 hold_full_q, hold_full_d;
   logic [DATA_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DATA_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d, word, word_sh;
   logic                 frame_start_q, frame_start_d, underrun_q, underrun_d;
`ifdef I2S_TX_LEFT_JUST_EN
`else
   logic                 lj_q, lj_d;
`endif

   always_comb begin
      sum           = acc_q + C_INC;
      tick          = (sum >= C_MOD);
      acc_d         = tick ? (sum - C_MOD) : sum;
      bck_d         = bck_q ^ tick;
      fall          = tick & bck_q;
      p             = (bit_idx_q == C_LAST_IDX) ? '0 : (bit_idx_q + C_ONE);
      boundary      = fall && (p == '0);
      accept        = s_if.s_valid && !hold_full_q;

      bit_idx_d     = bit_idx_q;
      lrck_d        = lrck_q;
      din_d         = din_q;
      hold_full_d   = hold_full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      act_l_d       = act_l_q;
      act_r_d       = act_r_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
`ifdef I2S_TX_LEFT_JUST_EN
`else
      lj_d          = lj_q;
`endif

      if (accept) begin
         hold_full_d = 1'b1;
         hold_l_d    = s_if.s_left;
         hold_r_d    = s_if.s_right;
      end

      // Transfer decision looks at the registered hold state only, so a
      // sample accepted in the boundary clk waits for the following frame.
      if (boundary) begin
         frame_start_d = 1'b1;
         if (hold_full_q) begin
            act_l_d     = hold_l_q;
            act_r_d     = hold_r_q;
            hold_full_d = 1'b0;
         end else begin
            act_l_d    = '0;
            act_r_d    = '0;
            underrun_d = 1'b1;
         end
      end

      slot_hi = (p >= C_SLOT);
      k       = slot_hi ? (p - C_SLOT) : p;
      word    = slot_hi ? act_r_d : act_l_d;
      // Positions past the sample width shift out as zero padding.
      word_sh = word << k;
      lj_bit  = word_sh[DATA_BITS-1];

      if (fall) begin
         bit_idx_d = p;
         lrck_d    = slot_hi;
`ifdef I2S_TX_LEFT_JUST_EN
         din_d     = lj_bit;
`else
         din_d     = lj_q;
         lj_d      = lj_bit;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst_i) begin
         acc_q         <= '0;
         bck_q         <= 1'b0;
         bit_idx_q     <= C_LAST_IDX;
         lrck_q        <= 1'b1;
         din_q         <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         act_l_q       <= '0;
         act_r_q       <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
`ifdef I2S_TX_LEFT_JUST_EN
`else
         lj_q          <= 1'b0;
`endif
      end else begin
         acc_q         <= acc_d;
         bck_q         <= bck_d;
         bit_idx_q     <= bit_idx_d;
         lrck_q        <= lrck_d;
         din_q         <= din_d;
         hold_full_q   <= hold_full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         act_l_q       <= act_l_d;
         act_r_q       <= act_r_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
`ifdef I2S_TX_LEFT_JUST_EN
`else
         lj_q          <= lj_d;
`endif
      end
   end

   assign s_if.s_ready = ~hold_full_q;
   assign i2s_bck      = bck_q;
   assign i2s_lrck     = lrck_q;
   assign i2s_din      = din_q;
   assign frame_start  = frame_start_q;
   assign underrun     = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_stream
// Purpose  : Directed self-checking bench for i2s_tx_stream (16/16 and 24/32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic bck_a, lrck_a, din_a, fs_a, ur_a;
   logic bck_b, lrck_b, din_b, fs_b, ur_b;

   i2s_tx_stream_if #(.DATA_BITS(16)) if_a ();
   i2s_tx_stream_if #(.DATA_BITS(24)) if_b ();

   i2s_tx_stream u_dut_a (
      .clk(clk), .sys_rst_i(rst_a), .s_if(if_a.slave),
      .i2s_bck(bck_a), .i2s_lrck(lrck_a), .i2s_din(din_a),
      .frame_start(fs_a), .underrun(ur_a)
   );

   i2s_tx_stream #(.DATA_BITS(24), .SLOT_BITS(32)) u_dut_b (
      .clk(clk), .sys_rst_i(rst_b), .s_if(if_b.slave),
      .i2s_bck(bck_b), .i2s_lrck(lrck_b), .i2s_din(din_b),
      .frame_start(fs_b), .underrun(ur_b)
   );

`ifdef I2S_TX_LEFT_JUST_EN
   localparam logic [16:0] C_T3_L  = {1'b0, 16'h8001};
   localparam logic [16:0] C_T3_R  = {1'b1, 16'h7FFE};
   localparam logic [32:0] C_B_L   = {1'b0, 32'hABCDEF00};
   localparam logic [32:0] C_B_R   = {1'b1, 32'h12345600};
   localparam logic [16:0] C_BP[6] = '{{1'b0, 16'h1234}, {1'b1, 16'h5678}, {1'b0, 16'h9ABC},
                                       {1'b1, 16'hDEF0}, {1'b0, 16'h2468}, {1'b1, 16'hACE0}};
`else
   localparam logic [16:0] C_T3_L  = {1'b0, 16'h4000};
   localparam logic [16:0] C_T3_R  = {1'b1, 16'hBFFF};
   localparam logic [32:0] C_B_L   = {1'b0, 32'h55E6F780};
   localparam logic [32:0] C_B_R   = {1'b1, 32'h091A2B00};
   localparam logic [16:0] C_BP[6] = '{{1'b0, 16'h091A}, {1'b1, 16'h2B3C}, {1'b0, 16'h4D5E},
                                       {1'b1, 16'h6F78}, {1'b0, 16'h1234}, {1'b1, 16'h5670}};
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Serial capture: slot words assembled from din on BCK rising edges.
   logic        bck_prev_a = 1'b0, lr_prev_a = 1'b1, lrck_last_a = 1'b1;
   int          pos_a = 100;
   logic [15:0] sh_a = '0;
   logic [16:0] words_a[$];
   int          fall_at_a[$];
   int          bck_rise_a = 0, fs_cnt_a = 0, ur_cnt_a = 0, din_ones_a = 0, nready_a = 0;

   initial forever begin
      @(negedge clk);
      if (rst_a === 1'b1) begin
         pos_a     = 100;
         lr_prev_a = 1'b1;
      end else if (bck_a === 1'b1 && bck_prev_a === 1'b0) begin
         bck_rise_a++;
         pos_a     = (lrck_a !== lr_prev_a) ? 0 : pos_a + 1;
         lr_prev_a = lrck_a;
         sh_a      = {sh_a[14:0], din_a};
         if (pos_a == 15) words_a.push_back({lrck_a, sh_a});
      end
      if (lrck_last_a === 1'b1 && lrck_a === 1'b0) fall_at_a.push_back(bck_rise_a);
      lrck_last_a = lrck_a;
      bck_prev_a  = bck_a;
      if (fs_a === 1'b1) fs_cnt_a++;
      if (ur_a === 1'b1) ur_cnt_a++;
      if (din_a === 1'b1) din_ones_a++;
      if (if_a.s_ready === 1'b0) nready_a++;
   end

   logic        bck_prev_b = 1'b0, lr_prev_b = 1'b1;
   int          pos_b = 100;
   logic [31:0] sh_b = '0;
   logic [32:0] words_b[$];

   initial forever begin
      @(negedge clk);
      if (rst_b === 1'b1) begin
         pos_b     = 100;
         lr_prev_b = 1'b1;
      end else if (bck_b === 1'b1 && bck_prev_b === 1'b0) begin
         pos_b     = (lrck_b !== lr_prev_b) ? 0 : pos_b + 1;
         lr_prev_b = lrck_b;
         sh_b      = {sh_b[30:0], din_b};
         if (pos_b == 31) words_b.push_back({lrck_b, sh_b});
      end
      bck_prev_b = bck_b;
   end

   // which: 0 = words_a, 1 = fall_at_a, 2 = words_b
   task automatic wait_for(input int which, input int n, input string tag);
      int c   = 0;
      int cur = 0;
      forever begin
         cur = (which == 0) ? words_a.size() : (which == 1) ? fall_at_a.size() : words_b.size();
         if (cur >= n || c >= 5000) break;
         @(posedge clk);
         c++;
      end
      check_eq(tag, 64'(cur >= n), 64'd1);
   endtask

   task automatic pulse_rst_a();
      @(posedge clk); #1 rst_a = 1'b1;
      @(posedge clk); #1 rst_a = 1'b0;
   endtask

   task automatic push_a(input logic [15:0] l, input logic [15:0] r,
                         output int waited, output logic fs_now, output int fs_at);
      if_a.s_valid = 1'b1;
      if_a.s_left  = l;
      if_a.s_right = r;
      waited       = 0;
      @(negedge clk);
      while (if_a.s_ready !== 1'b1 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      fs_now = fs_a;
      @(posedge clk);
      fs_at = fs_cnt_a;
      #1 if_a.s_valid = 1'b0;
      check_eq("push_accepted_in_time", 64'(waited < 2000), 64'd1);
   endtask

   initial begin
      int   base, ur0, fs0, ones0, nr0, w, fsat, c, c0, n;
      logic fsn;

      rst_a = 1'b1; rst_b = 1'b1;
      if_a.s_valid = 1'b0; if_a.s_left = '0; if_a.s_right = '0;
      if_b.s_valid = 1'b0; if_b.s_left = '0; if_b.s_right = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_bck",   bck_a,        0);
      check_eq("rst_lrck",  lrck_a,       1);
      check_eq("rst_din",   din_a,        0);
      check_eq("rst_ready", if_a.s_ready, 1);
      check_eq("rst_fs",    fs_a,         0);
      check_eq("rst_ur",    ur_a,         0);

      // Idle frames; DUT B gets its single sample right away.
      rst_a = 1'b0; rst_b = 1'b0;
      base = fall_at_a.size(); ur0 = ur_cnt_a; fs0 = fs_cnt_a;
      ones0 = din_ones_a; nr0 = nready_a;
      if_b.s_valid = 1'b1; if_b.s_left = 24'hABCDEF; if_b.s_right = 24'h123456;
      @(posedge clk); #1 if_b.s_valid = 1'b0;
      wait_for(1, base + 4, "idle_frames_seen");
      check_eq("idle_lrck_period_1", fall_at_a[base+1] - fall_at_a[base],   32);
      check_eq("idle_lrck_period_3", fall_at_a[base+3] - fall_at_a[base+2], 32);
      check_eq("idle_underruns",     ur_cnt_a - ur0,     4);
      check_eq("idle_frame_starts",  fs_cnt_a - fs0,     4);
      check_eq("idle_din_ones",      din_ones_a - ones0, 0);
      check_eq("idle_not_ready",     nready_a - nr0,     0);

      // Single sample 8001/7FFE pushed before the first boundary.
      pulse_rst_a();
      base = words_a.size(); ur0 = ur_cnt_a;
      if_a.s_valid = 1'b1; if_a.s_left = 16'h8001; if_a.s_right = 16'h7FFE;
      @(posedge clk); #1 if_a.s_valid = 1'b0;
      check_eq("ready_low_after_accept", if_a.s_ready, 0);
      wait_for(0, base + 4, "single_words_seen");
      check_eq("single_left",      words_a[base],   C_T3_L);
      check_eq("single_right",     words_a[base+1], C_T3_R);
      check_eq("single_next_left", words_a[base+2], 17'h00000);
      check_eq("single_underruns", ur_cnt_a - ur0,  1);

      // Backpressure with three samples offered back to back.
      pulse_rst_a();
      base = words_a.size(); ur0 = ur_cnt_a; fs0 = fs_cnt_a;
      push_a(16'h1234, 16'h5678, w, fsn, fsat);
      check_eq("bp_s0_immediate", w, 0);
      check_eq("bp_s0_before_boundary", fsat - fs0, 0);
      push_a(16'h9ABC, 16'hDEF0, w, fsn, fsat);
      check_eq("bp_s1_clk_after_boundary", fsn, 1);
      check_eq("bp_s1_boundary_count", fsat - fs0, 1);
      push_a(16'h2468, 16'hACE0, w, fsn, fsat);
      check_eq("bp_s2_clk_after_boundary", fsn, 1);
      check_eq("bp_s2_boundary_count", fsat - fs0, 2);
      wait_for(0, base + 6, "bp_words_seen");
      for (int i = 0; i < 6; i++) check_eq($sformatf("bp_word_%0d", i), words_a[base+i], C_BP[i]);
      check_eq("bp_no_underrun", ur_cnt_a - ur0, 0);

      // Reset in the middle of a right slot with data held.
      push_a(16'hFFFF, 16'hFFFF, w, fsn, fsat);
      push_a(16'hFFFF, 16'hFFFF, w, fsn, fsat);
      check_eq("held_before_reset", if_a.s_ready, 0);
      c = 0;
      while (!(lr_prev_a === 1'b1 && pos_a >= 4 && pos_a < 100) && c < 5000) begin
         @(posedge clk);
         c++;
      end
      check_eq("mid_right_reached", 64'(c < 5000), 64'd1);
      #1 rst_a = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_bck",   bck_a,        0);
      check_eq("midrst_lrck",  lrck_a,       1);
      check_eq("midrst_din",   din_a,        0);
      check_eq("midrst_ready", if_a.s_ready, 1);
      rst_a = 1'b0;
      base = words_a.size(); ur0 = ur_cnt_a;
      wait_for(0, base + 2, "midrst_words_seen");
      check_eq("midrst_left_zero", words_a[base], 17'h00000);
      check_eq("midrst_underrun",  ur_cnt_a - ur0, 1);

      // BCK rate over 6000 clk at 6 MHz: 1411.2 rising edges nominal.
      @(posedge clk); #1 rst_a = 1'b1;
      @(posedge clk); #1 rst_a = 1'b0;
      c0 = bck_rise_a;
      repeat (6000) @(posedge clk);
      @(negedge clk); #1;
      n = bck_rise_a - c0;
      check_eq("bck_rate_1410_to_1412", 64'(n >= 1410 && n <= 1412), 64'd1);

      // 24-bit data in 32-bit slots.
      wait_for(2, 3, "b_words_seen");
      check_eq("b_left",      words_b[0], C_B_L);
      check_eq("b_right",     words_b[1], C_B_R);
      check_eq("b_next_left", words_b[2], 33'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
